// File: rtl/alu_sru_seq.sv
// Control sequencer for the ALU serial Shift/Rotate Unit.
// A start edge latches the op and distance. The B register is then stepped once per
// clock, op_dist times, with the correct serial-in bit. For rotate-through-L ops, the
// L flag is stepped as well.
module alu_sru_seq #(
   parameter int DIST_W = 4
) (
   input  logic              clk4,
   input  logic              reset,
   input  logic              start,
   input  logic              op_rotate,
   input  logic              op_arithmetic,
   input  logic              op_right,
   input  logic [DIST_W-1:0] op_dist,
   input  logic              b15,
   input  logic              b0,
   input  logic              fl,
   output logic              busy,
   output logic              shift_en,
   output logic              shift_right,
   output logic              shift_in,
   output logic              fl_we,
   output logic              fl_d,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   // Latched op encoding: {rotate, arithmetic, right}
   localparam logic [2:0] OP_SHL = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_SHA = 3'b010;
   localparam logic [2:0] OP_ASR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
   localparam logic [2:0] OP_RLA = 3'b110;
   localparam logic [2:0] OP_RRA = 3'b111;

   state_t            state;
   logic [2:0]        op_q;
   logic [DIST_W-1:0] cnt;
   logic              start_q;
   logic              start_edge;

   assign start_edge = start & ~start_q;

   // Sequencer: start-edge detect, op/distance latch, step counter and sticky overrun flag
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk4 or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         start_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         start_q <= start;
         unique case (state)
            S_IDLE: begin
               if (start_edge) begin
                  op_q    <= {op_rotate, op_arithmetic, op_right};
                  cnt     <= op_dist;
                  overrun <= 1'b0;
                  state   <= (op_dist != '0) ? S_SHIFT : S_DONE;
               end
            end
            S_SHIFT: begin
               cnt <= cnt - 1'b1;
               if (cnt == DIST_W'(1)) state <= S_DONE;
               if (start_edge) overrun <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               if (start_edge) overrun <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Control strobes decode straight from the state register, so reset clears them at once
   assign busy        = (state == S_SHIFT);
   assign shift_en    = busy;
   assign done        = (state == S_DONE);
   assign shift_right = op_q[0];
   assign fl_we       = shift_en & (op_q == OP_ROL || op_q == OP_ROR);

   // Serial-in bit and next L value, chosen from the latched op and the live B/L bits
   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      shift_in = 1'b0;
      fl_d     = 1'b0;
      if (shift_en) begin
         unique case (op_q)
            OP_SHL, OP_SHR, OP_SHA: shift_in = 1'b0;
            OP_ASR: shift_in = b15;
            OP_ROL: begin
               shift_in = fl;
               fl_d     = b15;
            end
            OP_ROR: begin
               shift_in = fl;
               fl_d     = b0;
            end
            OP_RLA: shift_in = b15;
            OP_RRA: shift_in = b0;
            default: shift_in = 1'b0;
         endcase
      end
   end

endmodule
